alu_console_ctrl: RTL and testbench

- Parametrised, sequential successor to the board-level ALU test wrapper.
- Debounces pushbuttons and captures operands A/B from switches. Drives an external ALU with registered operands and opcode, then latches the result and flags.
- Renders any word width on a fixed bank of active-low 7-segment digits, using page scrolling and an overflow blink.
- Sits between board pins and the ALU under test.

---
 rtl/alu_console_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_alu_console_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_console_ctrl.sv
// alu_console_ctrl: board-side controller for an external ALU under test.
// Debounces four pushbuttons, captures sign-extended operands from switches,
// drives the ALU with registered operands and opcode, then latches the result
// and flags. It renders any word width on a bank of active-low 7-segment digits,
// using page scrolling and an overflow blink.
//
// Ports:
//   CLK, RST      clock; synchronous active-high reset
//   key_n[3:0]    raw active-low buttons: [0] load A, [1] load B, [2] execute, [3] page
//   sw_val/sw_sign operand value and sign (sign fills bits WORD_W-1:16)
//   sw_op         opcode sampled on execute
//   alu_porta/b   registered operands to the ALU
//   alu_op        registered opcode to the ALU
//   alu_result, alu_neg/zero/ovf  ALU outputs, latched one cycle after execute
//   hex_seg       digit d on [7d+6:7d], gfedcba, active-low
//   flag_led      latched {neg, zero, ovf}
//   page_led      current display page
module alu_console_ctrl #(
  parameter int unsigned WORD_W       = 32,
  parameter int unsigned OP_W         = 4,
  parameter int unsigned DIGITS       = 8,
  parameter int unsigned DB_CYCLES    = 250000,
  parameter int unsigned BLINK_CYCLES = 25000000
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [3:0]            key_n,
  input  logic [15:0]           sw_val,
  input  logic                  sw_sign,
  input  logic [OP_W-1:0]       sw_op,
  output logic [WORD_W-1:0]     alu_porta,
  output logic [WORD_W-1:0]     alu_portb,
  output logic [OP_W-1:0]       alu_op,
  input  logic [WORD_W-1:0]     alu_result,
  input  logic                  alu_neg,
  input  logic                  alu_zero,
  input  logic                  alu_ovf,
  output logic [DIGITS*7-1:0]   hex_seg,
  output logic [2:0]            flag_led,
  output logic [3:0]            page_led
);

  localparam int unsigned Nibbles = WORD_W / 4;
  localparam int unsigned NPages  = (WORD_W + 4 * DIGITS - 1) / (4 * DIGITS);
  localparam int unsigned DbW     = $clog2(DB_CYCLES);
  localparam int unsigned BlW     = $clog2(2 * BLINK_CYCLES);

  typedef enum logic [1:0] {StIdle, StExec, StShow} state_e;

  // ---------------------------------------------------------------------------
  // Key synchroniser and debounce
  // ---------------------------------------------------------------------------
  logic [3:0]          sync1_q, sync2_q;
  logic [3:0]          lvl_q, lvl_d;        // debounced level, 1 = pressed
  logic [3:0][DbW-1:0] db_cnt_q, db_cnt_d;
  logic [3:0]          press;
  logic [3:0]          pressed_s;

  assign pressed_s = ~sync2_q;

  always_comb begin
    lvl_d    = lvl_q;
    db_cnt_d = db_cnt_q;
    for (int k = 0; k < 4; k++) begin
      if (pressed_s[k] != lvl_q[k]) begin
        if (db_cnt_q[k] == DbW'(DB_CYCLES - 1)) begin
          lvl_d[k]    = pressed_s[k];
          db_cnt_d[k] = '0;
        end else begin
          db_cnt_d[k] = db_cnt_q[k] + DbW'(1);
        end
      end else begin
        db_cnt_d[k] = '0;
      end
    end
  end

  // One-cycle pulse on the released-to-pressed flip only.
  assign press = lvl_d & ~lvl_q;

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [WORD_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [2:0]        flags_q, flags_d;
  logic [3:0]        page_q, page_d;
  logic [BlW-1:0]    blink_q, blink_d;
  logic              src_b_q, src_b_d;
  logic [WORD_W-1:0] operand;

  // Truncating the oversized concatenation keeps WORD_W == 16 legal.
  assign operand = WORD_W'({{WORD_W{sw_sign}}, sw_val});

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    op_d    = op_q;
    flags_d = flags_q;
    page_d  = page_q;
    blink_d = blink_q;
    src_b_d = src_b_q;
    if (state_q == StExec) begin
      // The ALU is mid-evaluation; pulses landing here are dropped so the
      // operands it sees stay stable.
      res_d   = alu_result;
      flags_d = {alu_neg, alu_zero, alu_ovf};
      page_d  = '0;
      blink_d = '0;
      state_d = StShow;
    end else begin
      if (state_q == StShow && flags_q[0]) begin
        blink_d = (blink_q == BlW'(2 * BLINK_CYCLES - 1)) ? '0 : blink_q + BlW'(1);
      end
      if (press[2]) begin
        op_d    = sw_op;
        state_d = StExec;
      end else if (press[0]) begin
        a_d     = operand;
        src_b_d = 1'b0;
        page_d  = '0;
        state_d = StIdle;
      end else if (press[1]) begin
        b_d     = operand;
        src_b_d = 1'b1;
        page_d  = '0;
        state_d = StIdle;
      end else if (press[3]) begin
        page_d = (page_q == 4'(NPages - 1)) ? '0 : page_q + 4'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q  <= 4'hF;
      sync2_q  <= 4'hF;
      lvl_q    <= '0;
      db_cnt_q <= '0;
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      op_q     <= '0;
      flags_q  <= '0;
      page_q   <= '0;
      blink_q  <= '0;
      src_b_q  <= 1'b0;
    end else begin
      sync1_q  <= key_n;
      sync2_q  <= sync1_q;
      lvl_q    <= lvl_d;
      db_cnt_q <= db_cnt_d;
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      op_q     <= op_d;
      flags_q  <= flags_d;
      page_q   <= page_d;
      blink_q  <= blink_d;
      src_b_q  <= src_b_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Display decode (from registers only)
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] hex7(input logic [3:0] n);
    unique case (n)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  logic [WORD_W-1:0] disp_word;
  logic              blank_all;

  assign disp_word = (state_q == StShow) ? res_q : (src_b_q ? b_q : a_q);
  assign blank_all = (state_q == StShow) && flags_q[0] && (blink_q >= BlW'(BLINK_CYCLES));

  always_comb begin
    hex_seg = '1;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      int unsigned idx;
      idx = int'(page_q) * DIGITS + d;
      if (!blank_all && idx < Nibbles) begin
        hex_seg[7*d +: 7] = hex7(4'(disp_word >> (4 * idx)));
      end
    end
  end

  assign alu_porta = a_q;
  assign alu_portb = b_q;
  assign alu_op    = op_q;
  assign flag_led  = flags_q;
  assign page_led  = page_q;

endmodule

// File: tb/tb_alu_console_ctrl.sv
// Bench for alu_console_ctrl: three instances (32, 48, 64-bit words) share the
// same board stimulus; each has a behavioural model compared on every negedge,
// plus literal expectations for the key scenarios.
module tb_alu_console_ctrl;
  localparam int NI = 3;
  localparam int DB = 4;
  localparam int BL = 5;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  key_n;
  logic [15:0] sw_val;
  logic        sw_sign;
  logic [3:0]  sw_op;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] porta_w [NI];
  logic [55:0] hex_w   [NI];
  logic [2:0]  flag_w  [NI];
  logic [3:0]  page_w  [NI];
  logic [3:0]  op_w    [NI];

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  // Eight-character picture, most significant digit first; space = blank.
  function automatic logic [55:0] hex_str(input string s);
    logic [55:0] v;
    byte         ch;
    v = '1;
    for (int d = 0; d < 8; d++) begin
      ch = s[7-d];
      if (ch >= "0" && ch <= "9") v[7*d +: 7] = glyph(4'(ch - "0"));
      else if (ch >= "A" && ch <= "F") v[7*d +: 7] = glyph(4'(ch - "A" + 10));
    end
    return v;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int WW = (g == 0) ? 32 : ((g == 1) ? 48 : 64);
    localparam int NP = (WW + 31) / 32;
    localparam logic [63:0] Pat = 64'hDEADBEEF_01234567;

    logic [WW-1:0] porta, portb, result;
    logic [3:0]    op;
    logic          neg, zero, ovf;
    logic [55:0]   hex;
    logic [2:0]    flag;
    logic [3:0]    page;

    // Stand-in ALU: a few ops, op 7 yields a fixed pattern, op F forces ovf.
    function automatic logic [WW-1:0] alu_res(input logic [WW-1:0] a, b, input logic [3:0] o);
      logic [63:0] p;
      p = Pat;
      case (o)
        4'h0: return a & b;
        4'h1: return a | b;
        4'h2: return a ^ b;
        4'h4: return a - b;
        4'h7: return p[WW-1:0];
        default: return a + b;
      endcase
    endfunction

    function automatic logic [2:0] alu_flg(input logic [WW-1:0] a, b, input logic [3:0] o);
      logic [WW-1:0] r;
      logic          v;
      r = alu_res(a, b, o);
      v = (o == 4'hF) || (o != 4'h0 && o != 4'h1 && o != 4'h2 && o != 4'h4 && o != 4'h7 &&
                          a[WW-1] == b[WW-1] && r[WW-1] != a[WW-1]);
      return {r[WW-1], r == '0, v};
    endfunction

    assign result            = alu_res(porta, portb, op);
    assign {neg, zero, ovf}  = alu_flg(porta, portb, op);

    alu_console_ctrl #(
      .WORD_W(WW), .OP_W(4), .DIGITS(8), .DB_CYCLES(DB), .BLINK_CYCLES(BL)
    ) u_dut (
      .CLK(CLK), .RST(RST), .key_n(key_n), .sw_val(sw_val), .sw_sign(sw_sign), .sw_op(sw_op),
      .alu_porta(porta), .alu_portb(portb), .alu_op(op), .alu_result(result),
      .alu_neg(neg), .alu_zero(zero), .alu_ovf(ovf),
      .hex_seg(hex), .flag_led(flag), .page_led(page)
    );

    assign porta_w[g] = 64'(porta);
    assign hex_w[g]   = hex;
    assign flag_w[g]  = flag;
    assign page_w[g]  = page;
    assign op_w[g]    = op;

    // ---- behavioural model ----
    logic [WW-1:0] m_a, m_b, m_res;
    logic [3:0]    m_op;
    logic [2:0]    m_flg;
    int            m_page, m_mode, m_blink;   // mode: 0 idle, 1 exec, 2 show
    bit            m_srcb;
    logic [3:0]    m_raw1, m_raw2, m_lvl;
    int            m_run [4];

    always @(posedge CLK) begin : model
      logic [3:0] pr;
      logic [3:0] seen;
      pr = '0;
      if (RST) begin
        m_a = '0; m_b = '0; m_res = '0; m_op = '0; m_flg = '0;
        m_page = 0; m_mode = 0; m_blink = 0; m_srcb = 0;
        m_raw1 = '1; m_raw2 = '1; m_lvl = '0;
        for (int k = 0; k < 4; k++) m_run[k] = 0;
      end else begin
        // Level seen after two flops; flips once it has disagreed DB cycles running.
        seen = ~m_raw2;
        for (int k = 0; k < 4; k++) begin
          if (seen[k] == m_lvl[k]) m_run[k] = 0;
          else if (m_run[k] + 1 == DB) begin
            m_lvl[k] = seen[k];
            m_run[k] = 0;
            pr[k]    = seen[k];
          end else m_run[k]++;
        end
        m_raw2 = m_raw1;
        m_raw1 = key_n;
        if (m_mode == 1) begin
          m_res = alu_res(m_a, m_b, m_op);
          m_flg = alu_flg(m_a, m_b, m_op);
          m_page = 0; m_blink = 0; m_mode = 2;
        end else begin
          if (m_mode == 2 && m_flg[0]) m_blink = (m_blink + 1) % (2 * BL);
          if (pr[2]) begin
            m_op = sw_op; m_mode = 1;
          end else if (pr[0] || pr[1]) begin
            if (pr[0]) m_a = WW'({{48{sw_sign}}, sw_val});
            else       m_b = WW'({{48{sw_sign}}, sw_val});
            m_srcb = !pr[0]; m_page = 0; m_mode = 0;
          end else if (pr[3]) begin
            m_page = (m_page + 1) % NP;
          end
        end
      end
    end

    function automatic logic [55:0] exp_hex();
      logic [WW-1:0] src;
      logic [55:0]   v;
      int            idx;
      src = (m_mode == 2) ? m_res : (m_srcb ? m_b : m_a);
      v   = '1;
      if (!(m_mode == 2 && m_flg[0] && m_blink >= BL)) begin
        for (int d = 0; d < 8; d++) begin
          idx = m_page * 8 + d;
          if (idx < WW / 4) v[7*d +: 7] = glyph(4'(src >> (4 * idx)));
        end
      end
      return v;
    endfunction

    always @(negedge CLK) begin
      check($sformatf("u%0d.hex_seg", g), 64'(hex), 64'(exp_hex()));
      check($sformatf("u%0d.alu_porta", g), 64'(porta), 64'(m_a));
      check($sformatf("u%0d.alu_portb", g), 64'(portb), 64'(m_b));
      check($sformatf("u%0d.alu_op", g), 64'(op), 64'(m_op));
      check($sformatf("u%0d.flag_led", g), 64'(flag), 64'(m_flg));
      check($sformatf("u%0d.page_led", g), 64'(page), 64'(m_page));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic press(input int k, input int n);
    key_n[k] = 1'b0;
    tick(n);
    key_n[k] = 1'b1;
    tick(10);
  endtask

  initial begin
    RST = 1'b1; key_n = 4'hF; sw_val = '0; sw_sign = 1'b0; sw_op = '0;
    tick(2);
    RST = 1'b0;
    check("rst_hex0", 64'(hex_w[0]), 64'(hex_str("00000000")));
    check("rst_hex2", 64'(hex_w[2]), 64'(hex_str("00000000")));
    check("rst_flag", 64'(flag_w[0]), 64'h0);
    check("rst_page", 64'(page_w[0]), 64'h0);

    // Debounce: short press ignored, long press loads once.
    sw_val = 16'h1234;
    press(0, 3);
    check("short_press", porta_w[0], 64'h0);
    press(0, 10);
    check("load_a", porta_w[0], 64'h00001234);
    check("load_a_hex", 64'(hex_w[0]), 64'(hex_str("00001234")));

    // Sign extension and execute latency.
    sw_sign = 1'b1; sw_val = 16'hFFFE;
    press(0, 10);
    check("sext_a", porta_w[0], 64'hFFFFFFFE);
    check("sext_a48", porta_w[1], 64'h0000FFFFFFFFFFFE);
    sw_sign = 1'b0; sw_val = 16'h0003;
    press(1, 10);
    sw_op = 4'h3;
    key_n[2] = 1'b0;
    tick(6);
    check("exec_op", 64'(op_w[0]), 64'h3);
    check("exec_hex_b", 64'(hex_w[0]), 64'(hex_str("00000003")));
    tick(1);
    check("show_hex", 64'(hex_w[0]), 64'(hex_str("00000001")));
    check("show_flag", 64'(flag_w[0]), 64'h0);
    key_n[2] = 1'b1;
    tick(10);

    // Overflow blink: shown for BL cycles, then blank for BL.
    sw_op = 4'hF;
    key_n[2] = 1'b0;
    tick(7);
    check("ovf_flag", 64'(flag_w[0]), 64'h1);
    check("blink_on", 64'(hex_w[0]), 64'(hex_str("00000001")));
    tick(5);
    check("blink_off", 64'(hex_w[0]), 64'(hex_str("        ")));
    check("blink_flag", 64'(flag_w[0]), 64'h1);
    tick(5);
    check("blink_on2", 64'(hex_w[0]), 64'(hex_str("00000001")));
    key_n[2] = 1'b1;
    sw_sign = 1'b1; sw_val = 16'hFFFE;
    press(0, 10);
    check("blink_stop", 64'(hex_w[0]), 64'(hex_str("FFFFFFFE")));

    // Paging on wide words.
    sw_op = 4'h7;
    key_n[2] = 1'b0;
    tick(7);
    key_n[2] = 1'b1;
    check("pg0_64", 64'(hex_w[2]), 64'(hex_str("01234567")));
    check("pg0_48", 64'(hex_w[1]), 64'(hex_str("01234567")));
    key_n[3] = 1'b0;
    tick(6);
    check("pg1_64", 64'(hex_w[2]), 64'(hex_str("DEADBEEF")));
    check("pg1_led", 64'(page_w[2]), 64'h1);
    check("pg1_48", 64'(hex_w[1]), 64'(hex_str("    BEEF")));
    check("pg1_32", 64'(page_w[0]), 64'h0);
    key_n[3] = 1'b1;
    tick(10);
    key_n[3] = 1'b0;
    tick(6);
    check("pg_wrap", 64'(hex_w[2]), 64'(hex_str("01234567")));
    check("pg_wrap_led", 64'(page_w[2]), 64'h0);
    key_n[3] = 1'b1;
    tick(10);

    // Simultaneous execute and load A: execute wins.
    sw_sign = 1'b0; sw_val = 16'h5555; sw_op = 4'h0;
    key_n = 4'b1010;
    tick(6);
    check("prio_a", porta_w[0], 64'hFFFFFFFE);
    check("prio_op", 64'(op_w[0]), 64'h0);
    key_n = 4'hF;
    tick(10);

    // Reset during EXEC.
    key_n[2] = 1'b0;
    tick(6);
    RST = 1'b1; key_n = 4'hF;
    tick(1);
    RST = 1'b0;
    check("rst_exec_hex", 64'(hex_w[0]), 64'(hex_str("00000000")));
    check("rst_exec_a", porta_w[0], 64'h0);

    // Randomised board activity against the models.
    for (int i = 0; i < 400; i++) begin
      key_n   = 4'($urandom | $urandom);
      sw_val  = 16'($urandom);
      sw_sign = 1'($urandom);
      sw_op   = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) begin
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
      end
      tick($urandom_range(1, 12));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
